// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------------------------------------------------------------------
// Round-robin write arbiter that shares the single write port of a FIFO
// among NUM_REQ producers. The arbiter accepts one word per cycle into a
// one-entry holding register. It then presents that word to the FIFO write
// port. It never writes while the FIFO reports full.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_en      per-requester enable; a disabled requester is never granted
//   req_valid   per-requester "has a word" flag
//   req_data    packed requester words, requester i in [i*DATA_W +: DATA_W]
//   req_ready   one-hot grant, word taken when req_valid[i] && req_ready[i]
//   fifo_full   FIFO full status
//   fifo_wr     FIFO write strobe
//   fifo_wdata  FIFO write data (the held word)
//   grant_id    source index of the held word
//   busy        holding register occupied
//   stall_cnt   saturating count of cycles blocked by fifo_full
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;
    logic [ID_W-1:0]   hold_id;
    logic [ID_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] elig;
    logic               slot_free;
    logic               found;
    logic               accept;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    rr_next;
    logic [DATA_W-1:0]  req_words [NUM_REQ];

    // Drain side. The held word is written whenever the FIFO has room.
    assign fifo_wr    = hold_valid && !fifo_full;
    assign fifo_wdata = hold_data;
    assign grant_id   = hold_id;
    assign busy       = hold_valid;

    // The slot also counts as free when the held word leaves this cycle.
    // This allows one accept and one write in every cycle.
    assign slot_free = !hold_valid || fifo_wr;
    assign elig      = req_valid & req_en;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search starting at rr_ptr and wrapping modulo NUM_REQ.
    // The first eligible requester found wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
            if (!found && elig[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // rst_n gates the grant so that req_ready stays low while reset is held.
    // Without it, an empty slot would still produce a grant during reset.
    assign accept    = rst_n && slot_free && found;
    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rr_next   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= req_words[winner];
                hold_id    <= winner;
                rr_ptr     <= rr_next;
            end else if (fifo_wr) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Count cycles in which a held word is blocked by a full FIFO.
    // The counter saturates at its maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hold_valid && fifo_full && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the 64-bit FIFO memory among NUM_REQ producers (e.g. neuron-core spike packet sources or CPU-side writers). It accepts one request per cycle into a one-entry holding register, then drives the FIFO write strobe and data. It never writes while the FIFO reports full, so the FIFO overflow flag cannot set through this path. It also exposes the granted source ID and a saturating stall counter for debug and performance monitoring.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
DATA_W, 64, word width; must match the FIFO data width.
ID_W, 2, width of the grant ID; must satisfy 2^ID_W >= NUM_REQ.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_en  in  NUM_REQ  per-requester enable; when 0, that requester is never granted.
req_valid  in  NUM_REQ  requester i has a word to write.
req_data  in  NUM_REQ*DATA_W  requester i data, carried in slice [i*DATA_W +: DATA_W].
req_ready  out  NUM_REQ  one-hot grant; the word is accepted when req_valid[i] && req_ready[i].
fifo_full  in  1  FIFO full status.
fifo_wr  out  1  FIFO write strobe.
fifo_wdata  out  DATA_W  FIFO write data.
grant_id  out  ID_W  source index of the word in the holding register.
busy  out  1  holding register occupied.
stall_cnt  out  CNT_W  count of cycles blocked by fifo_full; saturating.

Behaviour:
- State:
  - hold_valid and hold_data[DATA_W], the holding register.
  - hold_id[ID_W].
  - rr_ptr[ID_W], the round-robin start pointer.
  - stall_cnt[CNT_W].
- Reset, asynchronous on rst_n low:
  - hold_valid=0, hold_data=0, hold_id=0, rr_ptr=0, stall_cnt=0.
  - Outputs during reset: fifo_wr=0, req_ready=0, busy=0, fifo_wdata=0, grant_id=0.
- Reset asserted mid-operation discards any held word. No FIFO write occurs while rst_n is low.
- Drain, combinational:
  - fifo_wr = hold_valid && !fifo_full.
  - fifo_wdata = hold_data; grant_id = hold_id; busy = hold_valid.
  - drain = fifo_wr.
- Slot free, combinational: slot_free = !hold_valid || drain.
  - A word can be accepted in the same cycle the held word drains, giving one write per cycle sustained.
- Eligibility: elig[i] = req_valid[i] && req_en[i].
- Arbitration, combinational, only when slot_free:
  - Winner is the first i with elig[i], searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready is one-hot at the winner and zero otherwise.
  - If slot_free=0 or no requester is eligible, req_ready=0.
- Requester side:
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  - Requesters hold req_valid and req_data stable until accepted.
- On an accept edge (winner w exists):
  - hold_data <= req_data[w]; hold_id <= w; hold_valid <= 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
- On a drain edge with no accept: hold_valid <= 0.
- With no accept, rr_ptr is unchanged.
- Latency: a word accepted at edge T is presented on fifo_wr in the cycle after T, and written at edge T+1 if fifo_full=0.
- Full FIFO:
  - hold_valid=1 and fifo_full=1 gives fifo_wr=0, req_ready=0, and the held word is retained unchanged.
  - stall_cnt increments by 1 per such cycle and saturates at 2^CNT_W-1; it never wraps.
- Empty path: hold_valid=0 gives fifo_wr=0 regardless of fifo_full.
- req_en deasserted while that requester holds the slot: the held word still drains; only future grants are blocked.
- No words are lost or duplicated: each accepted word produces exactly one fifo_wr pulse.

Test Plan:
1. Reset, then release with all req_valid=0 -> fifo_wr=0, req_ready=0, busy=0, stall_cnt=0 for 10 cycles.
2. Only requester 2 valid, streaming 0xA0..0xA7 with fifo_full=0 -> one accept per cycle; fifo_wr high for 8 consecutive cycles starting 1 cycle after the first accept; data in order; grant_id=2 throughout.
3. All 4 requesters continuously valid, fifo_full=0 -> grant sequence 0,1,2,3,0,1,...; 12 writes in 12 cycles; no requester granted twice before the others get a turn.
4. Hold fifo_full=1 for 20 cycles with a word held -> fifo_wr=0, req_ready=0, held data unchanged, stall_cnt=20. Then release full -> that word is written first, and streaming resumes.
5. CNT_W=4 with full held for 40 cycles -> stall_cnt stops at 15.
6. req_en=4'b1010 with all requesters valid -> grants alternate 1,3,1,3. Then pulse rst_n low mid-stream while busy=1 -> outputs reset immediately, the held word is never written, and after release the first grant comes from requester 1 (rr_ptr=0).
